// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Sequencer state: normal flow or waiting on the multicycle unit.
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_e;

  // EX operand source selects.
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
  localparam logic [1:0] FWD_MEM = 2'b01;  // result sitting in MEM
  localparam logic [1:0] FWD_WB  = 2'b10;  // result sitting in WB

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline status inputs and control outputs of the hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  // ID stage
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_is_mc;
  // EX producer
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  // MEM producer
  logic              mem_valid;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_write;
  // Control flow and multicycle unit
  logic              ex_branch_taken;
  logic              mc_done;
  // Controls
  logic              pc_en;
  logic              if_id_en;
  logic              id_ex_en;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              mc_start;
  logic              mc_timeout;
  logic              state;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_mc,
    output ex_valid, ex_rd, ex_reg_write, ex_mem_read,
    output mem_valid, mem_rd, mem_reg_write,
    output ex_branch_taken, mc_done,
    input  pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush,
    input  fwd_a, fwd_b, mc_start, mc_timeout, state, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_mc,
    input  ex_valid, ex_rd, ex_reg_write, ex_mem_read,
    input  mem_valid, mem_rd, mem_reg_write,
    input  ex_branch_taken, mc_done,
    output pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush,
    output fwd_a, fwd_b, mc_start, mc_timeout, state, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Forward-select for one EX operand: nearest non-load producer wins, x0 never forwards.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic              use_i,
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_reg_write_i,
  input  logic              ex_mem_read_i,
  input  logic              mem_valid_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_reg_write_i,
  output logic [1:0]        sel_o
);

  // Pick the youngest producer of rs; a load in EX has no data yet so it is skipped.
  always_comb begin
    sel_o = FWD_RF;
    if (use_i && (rs_i != {REG_AW{1'b0}})) begin
      if (ex_valid_i && ex_reg_write_i && !ex_mem_read_i && (ex_rd_i == rs_i)) begin
        sel_o = FWD_MEM;
      end else if (mem_valid_i && mem_reg_write_i && (mem_rd_i == rs_i)) begin
        sel_o = FWD_WB;
      end else begin
        sel_o = FWD_RF;
      end
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for a 5-stage pipeline: load-use stalls, branch flushes,
// registered operand forwarding and front-end freeze during multicycle ops.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 16,
  parameter int MC_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,   // asynchronous, active low
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int               CTR_W    = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(MC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic             mc_start_q, mc_start_d;
  logic             mc_timeout_q, mc_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       load_use_s;
  logic       pc_en_s, if_id_en_s, id_ex_en_s, if_id_flush_s, id_ex_flush_s;
  logic [1:0] fwd_a_s, fwd_b_s;

  assign load_use_s = bus.id_valid && bus.ex_valid && bus.ex_mem_read &&
                      (bus.ex_rd != {REG_AW{1'b0}}) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_i(bus.id_rs1), .use_i(bus.id_use_rs1),
    .ex_valid_i(bus.ex_valid), .ex_rd_i(bus.ex_rd),
    .ex_reg_write_i(bus.ex_reg_write), .ex_mem_read_i(bus.ex_mem_read),
    .mem_valid_i(bus.mem_valid), .mem_rd_i(bus.mem_rd),
    .mem_reg_write_i(bus.mem_reg_write), .sel_o(fwd_a_s)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_i(bus.id_rs2), .use_i(bus.id_use_rs2),
    .ex_valid_i(bus.ex_valid), .ex_rd_i(bus.ex_rd),
    .ex_reg_write_i(bus.ex_reg_write), .ex_mem_read_i(bus.ex_mem_read),
    .mem_valid_i(bus.mem_valid), .mem_rd_i(bus.mem_rd),
    .mem_reg_write_i(bus.mem_reg_write), .sel_o(fwd_b_s)
  );

  // Stage enables and flushes; a taken branch beats a load-use stall.
  always_comb begin
    pc_en_s       = 1'b1;
    if_id_en_s    = 1'b1;
    id_ex_en_s    = 1'b1;
    if_id_flush_s = 1'b0;
    id_ex_flush_s = 1'b0;
    if (!reset) begin
      pc_en_s       = 1'b0;
      if_id_en_s    = 1'b0;
      id_ex_en_s    = 1'b0;
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else begin
      case (state_q)
        ST_MC_WAIT: begin
          pc_en_s    = 1'b0;
          if_id_en_s = 1'b0;
          id_ex_en_s = 1'b0;
        end
        ST_RUN: begin
          if (bus.ex_branch_taken) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
          end else if (load_use_s) begin
            pc_en_s       = 1'b0;
            if_id_en_s    = 1'b0;
            id_ex_flush_s = 1'b1;
          end else begin
            pc_en_s = 1'b1;
          end
        end
        default: begin
          pc_en_s    = 1'b0;
          if_id_en_s = 1'b0;
          id_ex_en_s = 1'b0;
        end
      endcase
    end
  end

  // Next state for FSM, timeout counter, forward selects and stall counter.
  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    mc_start_d   = 1'b0;
    mc_timeout_d = mc_timeout_q;
    fwd_a_d      = fwd_a_q;
    fwd_b_d      = fwd_b_q;
    stall_cnt_d  = stall_cnt_q;

    if (id_ex_en_s && !id_ex_flush_s) begin
      fwd_a_d = fwd_a_s;
      fwd_b_d = fwd_b_s;
    end else if (id_ex_flush_s) begin
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
    end else begin
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
    end

    if (!pc_en_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    case (state_q)
      ST_RUN: begin
        if (bus.id_valid && bus.id_is_mc && !load_use_s && !bus.ex_branch_taken) begin
          state_d    = ST_MC_WAIT;
          mc_start_d = 1'b1;
          ctr_d      = {CTR_W{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MC_WAIT: begin
        if (bus.mc_done) begin
          state_d = ST_RUN;
        end else if (ctr_q == CTR_LAST) begin
          state_d      = ST_RUN;
          mc_timeout_d = 1'b1;
        end else begin
          ctr_d = ctr_q + {{(CTR_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      ctr_q        <= {CTR_W{1'b0}};
      fwd_a_q      <= FWD_RF;
      fwd_b_q      <= FWD_RF;
      mc_start_q   <= 1'b0;
      mc_timeout_q <= 1'b0;
      stall_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
      mc_start_q   <= mc_start_d;
      mc_timeout_q <= mc_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.pc_en       = pc_en_s;
  assign bus.if_id_en    = if_id_en_s;
  assign bus.id_ex_en    = id_ex_en_s;
  assign bus.if_id_flush = if_id_flush_s;
  assign bus.id_ex_flush = id_ex_flush_s;
  assign bus.fwd_a       = fwd_a_q;
  assign bus.fwd_b       = fwd_b_q;
  assign bus.mc_start    = mc_start_q;
  assign bus.mc_timeout  = mc_timeout_q;
  assign bus.state       = (state_q == ST_MC_WAIT);
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random
// traffic, all compared against a rule-level reference model.
module tb_pipeline_hazard_ctrl;
  localparam int AW  = 5;
  localparam int CW  = 6;   // narrow counter so saturation is reachable
  localparam int MCT = 64;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;

  pipeline_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW), .MC_TIMEOUT(MCT)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_mc, m_fa, m_fb, m_start, m_to, m_stall, m_wait;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mc = 0; m_fa = 0; m_fb = 0; m_start = 0; m_to = 0; m_stall = 0; m_wait = 0;
  endtask

  task automatic clear_inputs();
    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0; bus.id_is_mc = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_rd = '0; bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_reg_write = 1'b0;
    bus.ex_branch_taken = 1'b0; bus.mc_done = 1'b0;
  endtask

  task automatic rand_inputs();
    bus.id_valid = 1'($urandom_range(0, 3) != 0);
    bus.id_rs1 = AW'($urandom_range(0, 3));
    bus.id_rs2 = AW'($urandom_range(0, 3));
    bus.id_use_rs1 = 1'($urandom_range(0, 1));
    bus.id_use_rs2 = 1'($urandom_range(0, 1));
    bus.id_is_mc = 1'($urandom_range(0, 11) == 0);
    bus.ex_valid = 1'($urandom_range(0, 3) != 0);
    bus.ex_rd = AW'($urandom_range(0, 3));
    bus.ex_reg_write = 1'($urandom_range(0, 1));
    bus.ex_mem_read = 1'($urandom_range(0, 2) == 0);
    bus.mem_valid = 1'($urandom_range(0, 3) != 0);
    bus.mem_rd = AW'($urandom_range(0, 3));
    bus.mem_reg_write = 1'($urandom_range(0, 1));
    bus.ex_branch_taken = 1'($urandom_range(0, 7) == 0);
    bus.mc_done = 1'($urandom_range(0, 4) == 0);
  endtask

  // nearest producer that can supply rs: 1 = MEM, 2 = WB, 0 = regfile
  function automatic int pick_src(input int use_it, input int rs);
    if (use_it == 0 || rs == 0) return 0;
    if (bus.ex_valid && bus.ex_reg_write && !bus.ex_mem_read && int'(bus.ex_rd) == rs) return 1;
    if (bus.mem_valid && bus.mem_reg_write && int'(bus.mem_rd) == rs) return 2;
    return 0;
  endfunction

  task automatic check_regs(input string tag);
    check_eq({tag, ".fwd_a"}, 32'(bus.fwd_a), 32'(m_fa));
    check_eq({tag, ".fwd_b"}, 32'(bus.fwd_b), 32'(m_fb));
    check_eq({tag, ".mc_start"}, 32'(bus.mc_start), 32'(m_start));
    check_eq({tag, ".mc_timeout"}, 32'(bus.mc_timeout), 32'(m_to));
    check_eq({tag, ".state"}, 32'(bus.state), 32'(m_mc));
    check_eq({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(m_stall));
  endtask

  // one clock: check comb controls mid-cycle, advance model, check registers after edge
  task automatic cycle();
    int lu, e_pc, e_ifid, e_idex, e_fif, e_fid, na, nb;
    @(negedge clk);
    lu = (bus.id_valid && bus.ex_valid && bus.ex_mem_read && bus.ex_rd != 0 &&
          ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
           (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd))) ? 1 : 0;
    if (m_mc == 1)               begin e_pc = 0; e_ifid = 0; e_idex = 0; e_fif = 0; e_fid = 0; end
    else if (bus.ex_branch_taken) begin e_pc = 1; e_ifid = 1; e_idex = 1; e_fif = 1; e_fid = 1; end
    else if (lu == 1)            begin e_pc = 0; e_ifid = 0; e_idex = 1; e_fif = 0; e_fid = 1; end
    else                         begin e_pc = 1; e_ifid = 1; e_idex = 1; e_fif = 0; e_fid = 0; end
    check_eq("pc_en", 32'(bus.pc_en), 32'(e_pc));
    check_eq("if_id_en", 32'(bus.if_id_en), 32'(e_ifid));
    check_eq("id_ex_en", 32'(bus.id_ex_en), 32'(e_idex));
    check_eq("if_id_flush", 32'(bus.if_id_flush), 32'(e_fif));
    check_eq("id_ex_flush", 32'(bus.id_ex_flush), 32'(e_fid));
    na = pick_src(int'(bus.id_use_rs1), int'(bus.id_rs1));
    nb = pick_src(int'(bus.id_use_rs2), int'(bus.id_rs2));
    if (e_fid == 1)       begin m_fa = 0;  m_fb = 0;  end
    else if (e_idex == 1) begin m_fa = na; m_fb = nb; end
    if (e_pc == 0 && m_stall < CMAX) m_stall++;
    if (m_mc == 0) begin
      if (bus.id_valid && bus.id_is_mc && lu == 0 && !bus.ex_branch_taken) begin
        m_mc = 1; m_start = 1; m_wait = 0;
      end else begin
        m_start = 0;
      end
    end else begin
      m_start = 0;
      if (bus.mc_done) m_mc = 0;
      else if (m_wait == MCT - 1) begin m_mc = 0; m_to = 1; end
      else m_wait++;
    end
    @(posedge clk);
    #1;
    check_regs("reg");
  endtask

  // async reset, checked immediately and after being held for n edges
  task automatic do_reset(input int n);
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("rst.pc_en", 32'(bus.pc_en), 32'd0);
    check_eq("rst.id_ex_en", 32'(bus.id_ex_en), 32'd0);
    check_eq("rst.if_id_flush", 32'(bus.if_id_flush), 32'd1);
    check_eq("rst.id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
    check_regs("rst_now");
    repeat (n) @(posedge clk);
    #1;
    check_eq("rst_hold.if_id_en", 32'(bus.if_id_en), 32'd0);
    check_regs("rst_hold");
    reset = 1'b1;
  endtask

  task automatic set_load_use();
    clear_inputs();
    bus.id_valid = 1'b1; bus.id_rs1 = AW'(5); bus.id_rs2 = AW'(1);
    bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1;
    bus.ex_valid = 1'b1; bus.ex_rd = AW'(5); bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1;
  endtask

  initial begin
    int starts, s0;
    reset = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset(3);

    // load-use: lw x5 in EX, add x6,x5,x1 in ID
    set_load_use();
    cycle();
    check_eq("lu.stall_cnt", 32'(bus.stall_cnt), 32'd1);
    bus.ex_valid = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_rd = AW'(5); bus.mem_reg_write = 1'b1;
    cycle();
    check_eq("lu.fwd_a_wb", 32'(bus.fwd_a), 32'd2);
    check_eq("lu.fwd_b_rf", 32'(bus.fwd_b), 32'd0);

    // add x3 in EX (also x3 in MEM), sub x4,x3,x3 in ID: nearer producer wins
    clear_inputs();
    bus.id_valid = 1'b1; bus.id_rs1 = AW'(3); bus.id_rs2 = AW'(3);
    bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1;
    bus.ex_valid = 1'b1; bus.ex_rd = AW'(3); bus.ex_reg_write = 1'b1;
    bus.mem_valid = 1'b1; bus.mem_rd = AW'(3); bus.mem_reg_write = 1'b1;
    cycle();
    check_eq("fwd.a_mem", 32'(bus.fwd_a), 32'd1);
    check_eq("fwd.b_mem", 32'(bus.fwd_b), 32'd1);
    bus.id_rs1 = AW'(0); bus.id_rs2 = AW'(0); bus.ex_rd = AW'(0); bus.mem_rd = AW'(0);
    cycle();
    check_eq("fwd.a_x0", 32'(bus.fwd_a), 32'd0);
    check_eq("fwd.b_x0", 32'(bus.fwd_b), 32'd0);

    // branch taken together with load-use: no stall
    set_load_use();
    bus.ex_branch_taken = 1'b1;
    s0 = int'(bus.stall_cnt);
    cycle();
    check_eq("br.stall_cnt", 32'(bus.stall_cnt), 32'(s0));

    // mul, mc_done in the 6th MC_WAIT cycle -> 6 stall cycles
    clear_inputs();
    bus.id_valid = 1'b1; bus.id_is_mc = 1'b1;
    s0 = int'(bus.stall_cnt);
    cycle();
    starts = int'(bus.mc_start);
    clear_inputs();
    for (int i = 0; i < 6; i++) begin
      bus.mc_done = (i == 5) ? 1'b1 : 1'b0;
      cycle();
      starts += int'(bus.mc_start);
    end
    check_eq("mc.start_pulses", 32'(starts), 32'd1);
    check_eq("mc.stall_delta", 32'(int'(bus.stall_cnt) - s0), 32'd6);
    check_eq("mc.state_run", 32'(bus.state), 32'd0);

    // mul with no mc_done: timeout after 64 waiting cycles, sticky
    clear_inputs();
    bus.id_valid = 1'b1; bus.id_is_mc = 1'b1;
    cycle();
    clear_inputs();
    for (int i = 0; i < MCT - 1; i++) cycle();
    check_eq("to.still_waiting", 32'(bus.state), 32'd1);
    cycle();
    check_eq("to.state_run", 32'(bus.state), 32'd0);
    check_eq("to.flag", 32'(bus.mc_timeout), 32'd1);
    check_eq("to.stall_sat", 32'(bus.stall_cnt), 32'(CMAX));
    repeat (3) cycle();
    check_eq("to.sticky", 32'(bus.mc_timeout), 32'd1);

    // async reset in the middle of MC_WAIT
    bus.id_valid = 1'b1; bus.id_is_mc = 1'b1;
    cycle();
    clear_inputs();
    repeat (2) cycle();
    do_reset(3);

    // done and timeout in the same cycle: done wins, no timeout flag
    bus.id_valid = 1'b1; bus.id_is_mc = 1'b1;
    cycle();
    clear_inputs();
    for (int i = 0; i < MCT - 1; i++) cycle();
    bus.mc_done = 1'b1;
    cycle();
    check_eq("done_vs_to.state", 32'(bus.state), 32'd0);
    check_eq("done_vs_to.flag", 32'(bus.mc_timeout), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
